// File: rtl/instr_issue_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_issue_encoder
//  Description : Encodes ALU micro-ops (add/sub/xor/and/or, register or
//                immediate form) into 32-bit ibus words at push time, buffers
//                them in a DEPTH-entry FIFO and issues one word per clock to
//                the decode stage. An empty FIFO issues NOP_WORD bubbles; a
//                downstream stall freezes the issued word and the FIFO head.
//  Ports       : clk, reset (sync, active-high)
//                in_valid/in_ready handshake, in_op, in_imm, in_rs, in_rt,
//                in_rd, in_imm16 micro-op fields
//                stall        downstream hold
//                ibus         registered 32-bit instruction word
//                ibus_valid   registered, 1 = FIFO word, 0 = bubble
//                err          sticky illegal-op flag
//                issue_count  16-bit issued-word counter (optional)
//  Options     : define INSTR_ISSUE_COUNT_EN to add the issue_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_issue_encoder #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic        in_imm,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm16,
    input  logic        stall,
    output logic [31:0] ibus,
    output logic        ibus_valid,
    output logic        err
`ifdef INSTR_ISSUE_COUNT_EN
    ,
    output logic [15:0] issue_count
`endif
);

    localparam int              c_AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW       = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    logic [31:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic        w_legal;
    logic        w_push;
    logic        w_push_word;
    logic        w_pop;
    logic [5:0]  w_funct;
    logic [5:0]  w_opc;
    logic [31:0] w_word;

    // Ready is a pure function of the current occupancy: a full FIFO refuses
    // a push even on an edge where it also pops.
    assign in_ready    = (r_count != c_FULL);
    assign w_legal     = (in_op <= 3'd4);
    assign w_push      = in_valid & in_ready;
    // Illegal ops complete the handshake but never enter the FIFO.
    assign w_push_word = w_push & w_legal;
    assign w_pop       = ~stall & (r_count != '0);

    always_comb begin
        w_funct = 6'b000000;
        w_opc   = 6'b000000;
        case (in_op)
            3'd0: begin w_funct = 6'b000011; w_opc = 6'b000011; end
            3'd1: begin w_funct = 6'b000010; w_opc = 6'b000010; end
            3'd2: begin w_funct = 6'b000001; w_opc = 6'b000001; end
            3'd3: begin w_funct = 6'b000111; w_opc = 6'b001111; end
            3'd4: begin w_funct = 6'b000100; w_opc = 6'b001100; end
            default: begin w_funct = 6'b000000; w_opc = 6'b000000; end
        endcase
        if (in_imm) begin
            w_word = {w_opc, in_rs, in_rt, in_imm16};
        end else begin
            w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, w_funct};
        end
    end

    // Storage has no reset: entries are only ever read while count covers them.
    always_ff @(posedge clk) begin
        if (w_push_word) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            ibus       <= NOP_WORD;
            ibus_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (w_push_word) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_push && !w_legal) begin
                err <= 1'b1;
            end
            // With stall asserted ibus/ibus_valid and the head stay put.
            if (!stall) begin
                if (w_pop) begin
                    ibus       <= r_mem[r_rd_ptr];
                    ibus_valid <= 1'b1;
                    r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                end else begin
                    ibus       <= NOP_WORD;
                    ibus_valid <= 1'b0;
                end
            end
            case ({w_push_word, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef INSTR_ISSUE_COUNT_EN
    // Counts issued FIFO words; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_count <= 16'h0000;
        end else if (w_pop) begin
            issue_count <= issue_count + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_issue_encoder
//  Description : Self-checking bench for instr_issue_encoder. Directed steps
//                followed by random traffic, all compared against a queue-based
//                reference model of the issue buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issue_encoder;

    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_NOP   = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_imm;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm16;
    logic        stall;
    logic [31:0] ibus;
    logic        ibus_valid;
    logic        err;
`ifdef INSTR_ISSUE_COUNT_EN
    logic [15:0] issue_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_ibus  = c_NOP;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    int unsigned m_cnt   = 0;

    instr_issue_encoder #(
        .DEPTH    (c_DEPTH),
        .NOP_WORD (c_NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_imm     (in_imm),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm16   (in_imm16),
        .stall      (stall),
        .ibus       (ibus),
        .ibus_valid (ibus_valid),
        .err        (err)
`ifdef INSTR_ISSUE_COUNT_EN
        ,
        .issue_count(issue_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Encoding computed from field positions with plain arithmetic.
    function automatic logic [31:0] enc(input int op, input bit imm, input int rs,
                                        input int rt, input int rd, input int i16);
        int unsigned opc_t[5]   = '{3, 2, 1, 15, 12};
        int unsigned funct_t[5] = '{3, 2, 1, 7, 4};
        int unsigned w;
        if (imm) w = opc_t[op] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + i16;
        else     w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + funct_t[op];
        return w;
    endfunction

    task automatic drive(input bit v, input int op, input bit imm, input int rs, input int rt,
                         input int rd, input int i16, input bit st);
        in_valid = v;
        in_op    = 3'(op);
        in_imm   = imm;
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_imm16 = 16'(i16);
        stall    = st;
    endtask

    task automatic idle(input bit st);
        drive(1'b0, 0, 1'b0, 0, 0, 0, 0, st);
    endtask

    // One clock: check ready, advance the model, clock the DUT, compare outputs.
    task automatic step();
        bit push, pop;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < c_DEPTH));
        if (reset) begin
            mq.delete();
            m_ibus  = c_NOP;
            m_valid = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else begin
            push = in_valid && (mq.size() < c_DEPTH);
            pop  = !stall && (mq.size() > 0);
            if (!stall) begin
                if (pop) begin
                    m_ibus  = mq.pop_front();
                    m_valid = 1'b1;
                    m_cnt   = (m_cnt + 1) % 65536;
                end else begin
                    m_ibus  = c_NOP;
                    m_valid = 1'b0;
                end
            end
            if (push) begin
                if (in_op <= 3'd4) mq.push_back(enc(int'(in_op), in_imm, int'(in_rs), int'(in_rt),
                                                    int'(in_rd), int'(in_imm16)));
                else m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("ibus", ibus, m_ibus);
        chk("ibus_valid", 32'(ibus_valid), 32'(m_valid));
        chk("err", 32'(err), 32'(m_err));
`ifdef INSTR_ISSUE_COUNT_EN
        chk("issue_count", 32'(issue_count), m_cnt);
`endif
    endtask

    initial begin
        bit acc;
        int guard;
        reset = 1'b1;
        idle(1'b0);
        // 1: reset then idle
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("idle_ibus", ibus, 32'h00000000);
        chk("idle_valid", 32'(ibus_valid), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_err", 32'(err), 32'd0);

        // 2: register-form add, one-cycle issue latency, then bubble
        drive(1'b1, 0, 1'b0, 1, 2, 3, 0, 1'b0);
        step();
        chk("lat_not_yet", 32'(ibus_valid), 32'd0);
        idle(1'b0);
        step();
        chk("add_reg", ibus, 32'h00221803);
        chk("add_reg_v", 32'(ibus_valid), 32'd1);
        step();
        chk("bubble", 32'(ibus_valid), 32'd0);

        // 3: immediate forms
        drive(1'b1, 1, 1'b1, 4, 5, 0, 16'h1234, 1'b0);
        step();
        drive(1'b1, 3, 1'b1, 0, 31, 0, 16'hFFFF, 1'b0);
        step();
        chk("sub_imm", ibus, 32'h08851234);
        idle(1'b0);
        step();
        chk("and_imm", ibus, 32'h3C1FFFFF);
        step();

        // 4: fill while stalled, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i, 1'b0, i + 1, i + 2, i + 3, 0, 1'b1);
            step();
        end
        chk("full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 4, 1'b1, 7, 8, 0, 16'hBEEF, 1'b1);
        step();
        chk("held_ready", 32'(in_ready), 32'd0);
        stall = 1'b0;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 10) begin
            acc = in_ready;
            step();
            guard++;
        end
        chk("fifth_accepted", 32'(acc), 32'd1);
        idle(1'b0);
        repeat (6) step();

        // 5: illegal op sets sticky err; reset clears it and flushes
        drive(1'b1, 6, 1'b0, 1, 1, 1, 0, 1'b0);
        step();
        idle(1'b0);
        step();
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_noissue", 32'(ibus_valid), 32'd0);
        drive(1'b1, 2, 1'b0, 9, 10, 11, 0, 1'b1);
        step();
        drive(1'b1, 4, 1'b1, 12, 13, 0, 16'h5555, 1'b1);
        step();
        idle(1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) step();
        chk("flushed", 32'(ibus_valid), 32'd0);

        // 6: issue counter - 3 issued words plus 2 stall cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i, 1'b1, i, i, 0, i * 17, 1'b1);
            step();
        end
        idle(1'b1);
        repeat (2) step();
        idle(1'b0);
        repeat (5) step();
`ifdef INSTR_ISSUE_COUNT_EN
        chk("count3", 32'(issue_count), 32'd3);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 15) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
                  1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 65535),
                  $urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        idle(1'b0);
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
